// File: rtl/bin_to_bcd_converter.sv
// bin_to_bcd_converter: sequential binary to packed BCD converter (shift-add-3, one bit per clock).
//   Ports: clk_in, rst_n_in (async active-low), a_in [WIDTH] operand, en_in start request,
//          y_out [4*DIGITS] packed BCD (digit 0 in [3:0]), done one-cycle result pulse,
//          busy_out accept-to-done-drop, sign_out (only with BIN2BCD_SIGNED_EN).
//   Macro BIN2BCD_SIGNED_EN: treat a_in as two's complement, convert its magnitude, report the sign.
module bin_to_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [WIDTH-1:0]      a_in,
  input  logic                  en_in,
  output logic [4*DIGITS-1:0]   y_out,
  output logic                  done,
  output logic                  busy_out
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                  sign_out
`endif
);
  localparam int N  = 4*DIGITS + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, next;
  logic [N-1:0] sr, adj;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] mag;
  logic accept, last;
  assign accept = (state == IDLE) && en_in;
  assign last   = (state == SHIFT) && (cnt == CW'(1));
`ifdef BIN2BCD_SIGNED_EN
  logic sign_pend;
  assign mag = a_in[WIDTH-1] ? -a_in : a_in;
`else
  assign mag = a_in;
`endif
  // digits are corrected independently; a digit >= 5 becomes >= 8 so the shift carries into the next digit
  always_comb begin
    adj = sr;
    for (int i = 0; i < DIGITS; i++)
      if (sr[WIDTH+4*i +: 4] >= 4'd5) adj[WIDTH+4*i +: 4] = sr[WIDTH+4*i +: 4] + 4'd3;
  end
  always_comb begin
    next = state;
    if (accept) next = SHIFT;
    else if (last) next = DONE;
    else if (state == DONE) next = IDLE;
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      sr       <= '0;
      cnt      <= '0;
      y_out    <= '0;
      done     <= 1'b0;
      busy_out <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      sign_pend <= 1'b0;
      sign_out  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        sr       <= {{(4*DIGITS){1'b0}}, mag};
        cnt      <= CW'(WIDTH);
        busy_out <= 1'b1;
`ifdef BIN2BCD_SIGNED_EN
        sign_pend <= a_in[WIDTH-1];
`endif
      end else if (state == SHIFT) begin
        sr  <= {adj[N-2:0], 1'b0};
        cnt <= cnt - CW'(1);
        if (last) begin
          // BCD field of the final shifted register, taken straight from the adjusted value
          y_out <= adj[N-2 -: 4*DIGITS];
          done  <= 1'b1;
`ifdef BIN2BCD_SIGNED_EN
          sign_out <= sign_pend;
`endif
        end
      end else if (state == DONE) busy_out <= 1'b0;
    end
endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// tb_bin_to_bcd_converter: directed vector bench for bin_to_bcd_converter (WIDTH=8, DIGITS=3).
module tb_bin_to_bcd_converter;
  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [7:0]  a_in = '0;
  logic        en_in = 1'b0;
  logic [11:0] y_out;
  logic        done;
  logic        busy_out;
`ifdef BIN2BCD_SIGNED_EN
  logic        sign_out;
`endif
  int checks = 0;
  int failures = 0;

  bin_to_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .a_in(a_in),
    .en_in(en_in),
    .y_out(y_out),
    .done(done),
    .busy_out(busy_out)
`ifdef BIN2BCD_SIGNED_EN
    ,
    .sign_out(sign_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0]  a;
    logic [11:0] y;
    logic        s;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // request on one edge only, then scramble a_in to prove it is sampled at accept
  task automatic start(input logic [7:0] a);
    @(negedge clk_in);
    a_in = a;
    en_in = 1'b1;
    @(negedge clk_in);
    en_in = 1'b0;
    a_in = ~a;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 30) begin
      @(negedge clk_in);
      n++;
    end
  endtask

  initial begin
    int n, g, seen;
`ifdef BIN2BCD_SIGNED_EN
    vecs[0]  = '{8'hFF, 12'h001, 1'b1};
    vecs[1]  = '{8'h80, 12'h128, 1'b1};
    vecs[2]  = '{8'h7F, 12'h127, 1'b0};
    vecs[3]  = '{8'h00, 12'h000, 1'b0};
    vecs[4]  = '{8'h9C, 12'h100, 1'b1};
    vecs[5]  = '{8'h63, 12'h099, 1'b0};
    vecs[6]  = '{8'h01, 12'h001, 1'b0};
    vecs[7]  = '{8'hF6, 12'h010, 1'b1};
    vecs[8]  = '{8'h0A, 12'h010, 1'b0};
    vecs[9]  = '{8'h81, 12'h127, 1'b1};
    vecs[10] = '{8'h40, 12'h064, 1'b0};
    vecs[11] = '{8'hC8, 12'h056, 1'b1};
`else
    vecs[0]  = '{8'd0,   12'h000, 1'b0};
    vecs[1]  = '{8'd255, 12'h255, 1'b0};
    vecs[2]  = '{8'd1,   12'h001, 1'b0};
    vecs[3]  = '{8'd9,   12'h009, 1'b0};
    vecs[4]  = '{8'd10,  12'h010, 1'b0};
    vecs[5]  = '{8'd99,  12'h099, 1'b0};
    vecs[6]  = '{8'd100, 12'h100, 1'b0};
    vecs[7]  = '{8'd128, 12'h128, 1'b0};
    vecs[8]  = '{8'd199, 12'h199, 1'b0};
    vecs[9]  = '{8'd200, 12'h200, 1'b0};
    vecs[10] = '{8'd250, 12'h250, 1'b0};
    vecs[11] = '{8'd64,  12'h064, 1'b0};
`endif
    repeat (2) @(negedge clk_in);
    chk("reset_y", 32'(y_out), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_busy", 32'(busy_out), 32'h0);
    rst_n_in = 1'b1;

    for (int i = 0; i < 12; i++) begin
      start(vecs[i].a);
      chk($sformatf("busy_after_accept[%0d]", i), 32'(busy_out), 32'h1);
      wait_done(n);
      chk($sformatf("latency[%0d]", i), 32'(n), 32'd9);
      chk($sformatf("y[%0d]", i), 32'(y_out), 32'(vecs[i].y));
      chk($sformatf("busy_at_done[%0d]", i), 32'(busy_out), 32'h1);
`ifdef BIN2BCD_SIGNED_EN
      chk($sformatf("sign[%0d]", i), 32'(sign_out), 32'(vecs[i].s));
`endif
      @(negedge clk_in);
      chk($sformatf("done_drop[%0d]", i), 32'(done), 32'h0);
      chk($sformatf("busy_drop[%0d]", i), 32'(busy_out), 32'h0);
      chk($sformatf("y_hold[%0d]", i), 32'(y_out), 32'(vecs[i].y));
    end

    // second request mid-conversion must be ignored
    start(8'd99);
    repeat (3) @(negedge clk_in);
    en_in = 1'b1;
    a_in = 8'd7;
    wait_done(n);
    en_in = 1'b0;
    chk("midshift_y", 32'(y_out), 32'h099);
    repeat (3) @(negedge clk_in);
    chk("midshift_no_restart", 32'(busy_out), 32'h0);
    chk("midshift_y_hold", 32'(y_out), 32'h099);

`ifndef BIN2BCD_SIGNED_EN
    // en_in held high: back-to-back conversions 10 cycles apart
    @(negedge clk_in);
    a_in = 8'd128;
    en_in = 1'b1;
    @(negedge clk_in);
    wait_done(n);
    chk("b2b_latency", 32'(n), 32'd9);
    chk("b2b_y1", 32'(y_out), 32'h128);
    a_in = 8'd64;
    g = 0;
    do begin
      @(negedge clk_in);
      g++;
    end while (done !== 1'b1 && g < 30);
    chk("b2b_gap", 32'(g), 32'd10);
    chk("b2b_y2", 32'(y_out), 32'h064);
    en_in = 1'b0;
    repeat (2) @(negedge clk_in);

    // async reset mid-conversion aborts without a done pulse
    start(8'd200);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    chk("abort_y", 32'(y_out), 32'h0);
    chk("abort_busy", 32'(busy_out), 32'h0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_in);
      if (c == 2) rst_n_in = 1'b1;
      if (done === 1'b1) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'h0);
    start(8'd200);
    wait_done(n);
    chk("after_abort_latency", 32'(n), 32'd9);
    chk("after_abort_y", 32'(y_out), 32'h200);
`endif
    @(negedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
